registerfile: RTL

Architectural register file and status register sitting directly downstream of pipeline stage 2. Consumes stage 2's write controls (memory/branch-link data writes, immediate loads, ALU writebacks, status-register writes) and performs them on the clock edge. Supplies three combinational read ports with same-cycle write bypass to stages 0/1. Exports the live condition flags that stage 2 uses to evaluate branch/jump conditions. Keeps a per-register busy scoreboard so upstream stages can detect read-after-write hazards.

---
 rtl/registerfile_pkg.sv | 40 ++++
 rtl/registerfile_if.sv | 43 ++++
 rtl/registerfile_scoreboard.sv | 36 +++
 rtl/registerfile.sv | 73 +++++++
 4 files changed

// File: rtl/registerfile_pkg.sv
`default_nettype none
// Shared types for the architectural register file: immediate-load encodings,
// status flag layout and the immediate merge helper.
package registerfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int DATA_W   = 32;
    localparam int IMM_W    = 16;

    typedef enum logic [1:0] {
        IT_UNSIGNED = 2'd0,
        IT_SIGNED   = 2'd1,
        IT_TOP      = 2'd2,
        IT_BOTTOM   = 2'd3
    } imm_type_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic over;
    } flags_t;

    // TOP/BOTTOM keep the untouched half of the destination's current contents.
    function automatic logic [DATA_W-1:0] imm_value(input imm_type_e         kind,
                                                    input logic [IMM_W-1:0]  imm,
                                                    input logic [DATA_W-1:0] old);
        logic [DATA_W-1:0] v;
        case (kind)
            IT_UNSIGNED: v = {16'h0000, imm};
            IT_SIGNED:   v = {{16{imm[15]}}, imm};
            IT_TOP:      v = {imm, old[15:0]};
            default:     v = {old[31:16], imm};
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/registerfile_if.sv
`default_nettype none
// Stage-2 write controls, stage-0/1 read ports, claim/hazard scoreboard and
// status flags between the pipeline and the register file.
interface registerfile_if;
    import registerfile_pkg::*;

    logic              write;
    logic [IDX_W-1:0]  write_index;
    logic [DATA_W-1:0] write_data;
    logic              write_immediate;
    logic [1:0]        write_immediate_type;
    logic [IMM_W-1:0]  write_immediate_data;
    logic              alu_cycle;
    logic [DATA_W-1:0] alu_result;
    logic              status_register_write;
    logic              alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in;
    logic [IDX_W-1:0]  read_reg_a_index, read_reg_b_index, read_reg_c_index;
    logic [DATA_W-1:0] read_reg_a_data, read_reg_b_data, read_reg_c_data;
    logic              claim;
    logic [IDX_W-1:0]  claim_index;
    logic              hazard;
    logic              alu_carry, alu_zero, alu_neg, alu_over;

    modport master (
        output write, write_index, write_data, write_immediate, write_immediate_type,
               write_immediate_data, alu_cycle, alu_result, status_register_write,
               alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in,
               read_reg_a_index, read_reg_b_index, read_reg_c_index, claim, claim_index,
        input  read_reg_a_data, read_reg_b_data, read_reg_c_data, hazard,
               alu_carry, alu_zero, alu_neg, alu_over
    );

    modport slave (
        input  write, write_index, write_data, write_immediate, write_immediate_type,
               write_immediate_data, alu_cycle, alu_result, status_register_write,
               alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in,
               read_reg_a_index, read_reg_b_index, read_reg_c_index, claim, claim_index,
        output read_reg_a_data, read_reg_b_data, read_reg_c_data, hazard,
               alu_carry, alu_zero, alu_neg, alu_over
    );

endinterface
`default_nettype wire

// File: rtl/registerfile_scoreboard.sv
`default_nettype none
// Per-register busy bits: a claim marks an issued writer in flight, a completed
// write releases it; hazard flags any read port touching a busy register.
module registerfile_scoreboard
    import registerfile_pkg::*;
(
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             claim_i,
    input  wire logic [IDX_W-1:0] claim_index_i,
    input  wire logic             clear_i,
    input  wire logic [IDX_W-1:0] clear_index_i,
    input  wire logic [IDX_W-1:0] rd_a_index_i,
    input  wire logic [IDX_W-1:0] rd_b_index_i,
    input  wire logic [IDX_W-1:0] rd_c_index_i,
    output logic                  hazard_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Clear first so a same-index claim in the same cycle keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clear_i) busy_d[clear_index_i] = 1'b0;
        if (claim_i) busy_d[claim_index_i] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign hazard_o = busy_q[rd_a_index_i] | busy_q[rd_b_index_i] | busy_q[rd_c_index_i];

endmodule
`default_nettype wire

// File: rtl/registerfile.sv
`default_nettype none
// 16x32 architectural register file with status flags, immediate merge loads,
// optional same-cycle write bypass on three read ports and a busy scoreboard.
module registerfile
    import registerfile_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    registerfile_if.slave rf
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] wr_value_d;
    logic              wr_en_d;
    flags_t            flags_q, flags_d;

    always_comb begin
        wr_en_d    = rf.write | rf.write_immediate;
        wr_value_d = rf.write_data;
        if (rf.write_immediate)
            wr_value_d = imm_value(imm_type_e'(rf.write_immediate_type),
                                   rf.write_immediate_data, regs_q[rf.write_index]);
        else if (rf.alu_cycle)
            wr_value_d = rf.alu_result;
    end

    always_comb begin
        flags_d = flags_q;
        if (rf.status_register_write)
            flags_d = '{carry: rf.alu_carry_in, zero: rf.alu_zero_in,
                        neg: rf.alu_neg_in, over: rf.alu_over_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            flags_q <= '0;
        end else begin
            if (wr_en_d) regs_q[rf.write_index] <= wr_value_d;
            flags_q <= flags_d;
        end
    end

    // Bypass forwards the final merged value, so TOP/BOTTOM loads read coherently.
    assign rf.read_reg_a_data = (BYPASS && wr_en_d && rf.read_reg_a_index == rf.write_index)
                                ? wr_value_d : regs_q[rf.read_reg_a_index];
    assign rf.read_reg_b_data = (BYPASS && wr_en_d && rf.read_reg_b_index == rf.write_index)
                                ? wr_value_d : regs_q[rf.read_reg_b_index];
    assign rf.read_reg_c_data = (BYPASS && wr_en_d && rf.read_reg_c_index == rf.write_index)
                                ? wr_value_d : regs_q[rf.read_reg_c_index];

    assign rf.alu_carry = flags_q.carry;
    assign rf.alu_zero  = flags_q.zero;
    assign rf.alu_neg   = flags_q.neg;
    assign rf.alu_over  = flags_q.over;

    registerfile_scoreboard u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .claim_i       (rf.claim),
        .claim_index_i (rf.claim_index),
        .clear_i       (wr_en_d),
        .clear_index_i (rf.write_index),
        .rd_a_index_i  (rf.read_reg_a_index),
        .rd_b_index_i  (rf.read_reg_b_index),
        .rd_c_index_i  (rf.read_reg_c_index),
        .hazard_o      (rf.hazard)
    );

endmodule
`default_nettype wire
